// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the register-bank bus master.
// Optional read-back verify: define REG_BANK_READBACK_VERIFY_EN.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;
  localparam int RD_LAT_DEF = 1;
  localparam int RD_LAT_MAX = 15;
  localparam int TMR_W      = $clog2(16);

  // Timer preload: the last count cycle is the one where the counter reads 0.
  function automatic logic [TMR_W-1:0] lat_load(input int lat);
    return TMR_W'(lat - 1);
  endfunction

endpackage

// File: rtl/reg_bank_master_if.sv
// Command, response and register-bank bus signals of the master.
// master: the initiator block; slave: sequencer + bank side.
interface reg_bank_master_if
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_rw;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              rw;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rw, rsp_rdata, rsp_err,
    input  rsp_ready,
    output address, data_in, rw,
    input  data_out
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rw, rsp_rdata, rsp_err,
    output rsp_ready,
    input  address, data_in, rw,
    output data_out
  );

endinterface

// File: rtl/reg_bank_rd_timer.sv
// Loadable down-counter timing the bank read latency.
// done is high while the count sits at zero.
module reg_bank_rd_timer
  import reg_bank_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Load on start, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/reg_bank_master.sv
// Single-outstanding register-bank bus master (cmd -> bus -> rsp).
// Define REG_BANK_READBACK_VERIFY_EN to read back and compare every write.
module reg_bank_master
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = RD_LAT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  reg_bank_master_if.master bus,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [TMR_W-1:0] TMR_LOAD = lat_load(READ_LATENCY);

  state_e state_q;
  state_e state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;
  logic              rsp_rw_q;
  logic              rsp_rw_d;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_q;
  logic              rsp_err_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic tmr_start;
  logic tmr_done;

  reg_bank_rd_timer u_rd_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (tmr_start),
    .load_val (TMR_LOAD),
    .done     (tmr_done)
  );

  // Next-state and transaction bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rw_d    = rsp_rw_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    tmr_start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d      = bus.cmd_addr;
          rsp_rw_d    = bus.cmd_rw;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (bus.cmd_rw == RW_WRITE) begin
            wdata_d = bus.cmd_wdata;
            state_d = WRITE;
          end else begin
            tmr_start = 1'b1;
            state_d   = READ;
          end
        end
      end
      WRITE: begin
`ifdef REG_BANK_READBACK_VERIFY_EN
        tmr_start = 1'b1;
        state_d   = READ;
`else
        state_d = RESP;
`endif
      end
      READ: begin
        if (tmr_done) begin
          rsp_rdata_d = bus.data_out;
`ifdef REG_BANK_READBACK_VERIFY_EN
          if (rsp_rw_q == RW_WRITE) begin
            rsp_err_d = (bus.data_out != wdata_q);
          end
`endif
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rw_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rw_q    <= rsp_rw_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rw    = rsp_rw_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.address   = addr_q;
  assign bus.data_in   = wdata_q;
  assign bus.rw        = (state_q == WRITE);
  assign busy          = (state_q != IDLE);
  assign txn_count     = cnt_q;

endmodule

// File: tb/tb_reg_bank_master.sv
// Randomized + directed bench for reg_bank_master against a transaction model.
// Works with and without REG_BANK_READBACK_VERIFY_EN.
module tb_reg_bank_master;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 3;
  localparam int CW  = 8;
  localparam logic [AW-1:0] STUCK_ADDR = 8'hF0;
`ifdef REG_BANK_READBACK_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          busy;
  logic [CW-1:0] txn_count;

  reg_bank_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_bank_master #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT), .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] stored(input logic [AW-1:0] a,
                                           input logic [DW-1:0] d);
    return (a == STUCK_ADDR) ? (d & 16'hFFFE) : d;
  endfunction

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 5) ? 16'h1234 : 16'((i * 16'h0101) ^ 16'h5A5A);
  endfunction

  // Register bank: write on rw, read data appears LAT cycles after address.
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] pipe [LAT-1];
  initial for (int i = 0; i < 256; i++) mem[i] = init_val(i);
  always @(posedge clk) begin
    if (bus.rw) mem[bus.address] <= stored(bus.address, bus.data_in);
    pipe[0] <= mem[bus.address];
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.data_out = pipe[LAT-2];

  // Transaction-level reference model.
  logic [DW-1:0] ref_mem [256];
  initial for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

  int            cyc = 0;
  bit            m_busy = 0;
  int            m_acc, m_due;
  logic          m_rw;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata;
  logic          m_err;
  logic [CW-1:0] m_cnt = '0;

  // Per-cycle compare, then advance the model on observed handshakes.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rw", bus.rw, 0);
      chk("rst_address", bus.address, 0);
      chk("rst_data_in", bus.data_in, 0);
      chk("rst_rdata", bus.rsp_rdata, 0);
      chk("rst_err", bus.rsp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", txn_count, 0);
      m_busy  = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_cnt   = '0;
    end else begin
      logic exp_rsp;
      exp_rsp = m_busy && (cyc >= m_due);
      chk("cmd_ready", bus.cmd_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("rsp_valid", bus.rsp_valid, exp_rsp);
      chk("rw", bus.rw, m_busy && m_rw && (cyc == m_acc + 1));
      chk("address", bus.address, m_addr);
      chk("data_in", bus.data_in, m_wdata);
      chk("txn_count", txn_count, m_cnt);
      if (exp_rsp) begin
        chk("rsp_rw", bus.rsp_rw, m_rw);
        chk("rsp_rdata", bus.rsp_rdata, m_rdata);
        chk("rsp_err", bus.rsp_err, m_err);
      end
      if (exp_rsp && bus.rsp_ready) begin
        m_busy = 0;
        m_cnt  = m_cnt + 1'b1;
      end else if (!m_busy && bus.cmd_valid) begin
        m_busy = 1;
        m_acc  = cyc;
        m_rw   = bus.cmd_rw;
        m_addr = bus.cmd_addr;
        if (bus.cmd_rw) begin
          m_wdata = bus.cmd_wdata;
          ref_mem[m_addr] = stored(m_addr, m_wdata);
          m_due   = VER ? cyc + 2 + LAT : cyc + 2;
          m_rdata = VER ? ref_mem[m_addr] : '0;
          m_err   = VER ? (ref_mem[m_addr] != m_wdata) : 1'b0;
        end else begin
          m_due   = cyc + 1 + LAT;
          m_rdata = ref_mem[m_addr];
          m_err   = 1'b0;
        end
      end
    end
    cyc++;
  end

  // Issue one command and wait for the DUT to take it.
  task automatic send(input logic r, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("cmd_ready_timeout", 0, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = r;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = 16'($urandom);
  endtask

  // Full transaction; lat = cycles from accept edge to rsp_valid.
  task automatic txn(input logic r, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input int hold,
                     output logic [DW-1:0] rd, output logic er,
                     output int lat);
    send(r, a, d);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 40) chk("rsp_timeout", 0, 1);
    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2 && hold >= 3) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = 1'($urandom);
        bus.cmd_addr  = 8'($urandom_range(0, 7));
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            lat;
  bit            saw_rsp;

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Write then read back through the bus.
    txn(1'b1, 8'h12, 16'hBEEF, 0, rd, er, lat);
    chk("wr_latency", lat, VER ? 2 + LAT : 2);
    txn(1'b0, 8'h12, 16'h0000, 0, rd, er, lat);
    chk("rd_beef", rd, 16'hBEEF);
    chk("rd_latency", lat, 1 + LAT);
    chk("count_two", txn_count, 2);

    // Preloaded location, latency 3 -> response 4 cycles after accept.
    txn(1'b0, 8'h05, 16'h0000, 0, rd, er, lat);
    chk("rd_1234", rd, 16'h1234);
    chk("rd5_latency", lat, 4);

    // Backpressure for 10 cycles with a stray cmd_valid pulse inside.
    txn(1'b0, 8'h05, 16'h0000, 10, rd, er, lat);
    chk("bp_rdata", rd, 16'h1234);
    chk("bp_count", txn_count, 4);

    // Reset one cycle after accept aborts the read.
    send(1'b0, 8'h07, 16'h0000);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_address", bus.address, 0);
    chk("arst_count", txn_count, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    saw_rsp = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) saw_rsp = 1;
    end
    chk("arst_no_rsp", saw_rsp, 0);
    txn(1'b0, 8'h05, 16'h0000, 1, rd, er, lat);
    chk("post_rst_rdata", rd, 16'h1234);
    chk("post_rst_count", txn_count, 1);

    // Stuck-at-0 bit 0 at the special address.
    txn(1'b1, STUCK_ADDR, 16'h0001, 0, rd, er, lat);
    chk("stuck1_rdata", rd, 16'h0000);
    chk("stuck1_err", er, VER ? 1 : 0);
    txn(1'b1, STUCK_ADDR, 16'h0002, 0, rd, er, lat);
    chk("stuck2_rdata", rd, VER ? 16'h0002 : 16'h0000);
    chk("stuck2_err", er, 0);

    // Random traffic over a small address set.
    for (int i = 0; i < 200; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 9) == 0) ? STUCK_ADDR
                                      : 8'($urandom_range(0, 7));
      txn(1'($urandom), a, 16'($urandom), $urandom_range(0, 4),
          rd, er, lat);
    end

    // Drive the counter to all-ones, then one more wraps it to 0.
    for (int i = 0; i < 300 && m_cnt != 8'hFF; i++) begin
      txn(1'b1, 8'h03, 16'($urandom), 0, rd, er, lat);
    end
    chk("pre_wrap", txn_count, 8'hFF);
    txn(1'b0, 8'h05, 16'h0000, 0, rd, er, lat);
    chk("wrap_zero", txn_count, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
